multu_sequencer: RTL and testbench

Multi-cycle controller for the MULTU instruction and owner of the HI/LO register pair. It sits beside the combinational ALU/shifter stage of the pipeline. It accepts MULTU, MFHI and MFLO function codes from the execute stage and runs a 32-iteration unsigned shift-add multiply. It reports stalls to the pipeline until the result is committed to HI/LO and serves MFHI/MFLO reads.

---
 rtl/multu_sequencer.sv | 96 +++++++++
 tb/tb_multu_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multu_sequencer.sv
// MULTU sequencer: 32-iteration unsigned shift-add multiplier that owns HI/LO,
// stalls the pipeline while iterating and serves MFHI/MFLO reads.
module multu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int                CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WIDTH - 1);
  localparam logic [5:0]        F_MULTU = 6'b011001;
  localparam logic [5:0]        F_MFHI  = 6'b010000;
  localparam logic [5:0]        F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH:0]       sum;
  logic                 accept;

  // A new multiply can only start outside RUN; during RUN the request is stalled instead.
  assign accept = issue && (funct == F_MULTU) && (state != RUN);

  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) begin
      sum = sum + {1'b0, mcand};
    end
    prod_next = {sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
        cnt   <= '0;
      end else if (state == RUN) begin
        prod <= prod_next;
        cnt  <= cnt + 1'b1;
        // HI/LO are committed from the final iteration's product, not the registered one.
        if (cnt == LAST) begin
          hi <= prod_next[2*WIDTH-1:WIDTH];
          lo <= prod_next[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = accept ? RUN : IDLE;
      RUN:        next_state = (cnt == LAST) ? DONE : RUN;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    stall   = issue && busy &&
              ((funct == F_MULTU) || (funct == F_MFHI) || (funct == F_MFLO));
    rd_data = '0;
    if (funct == F_MFHI) begin
      rd_data = hi;
    end else if (funct == F_MFLO) begin
      rd_data = lo;
    end
  end

endmodule

// File: tb/tb_multu_sequencer.sv
// Scoreboard bench for multu_sequencer: expected products from plain 64-bit
// multiplication are queued at issue and popped by a monitor on each done pulse.
module tb_multu_sequencer;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk;
  logic        rst;
  logic        issue;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int          checks;
  int          passes;
  logic [63:0] expq[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  multu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .issue(issue), .funct(funct), .a(a), .b(b),
    .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'b0, x};
    yy = {32'b0, y};
    return xx * yy;
  endfunction

  function automatic logic stallsInRun(input logic [5:0] f);
    return (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

  function automatic logic [5:0] pickFunct(input int k);
    case (k)
      0:       return F_MULTU;
      1:       return F_MFHI;
      2:       return F_MFLO;
      default: return F_ADD;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks MF reads against committed HI/LO.
  always @(negedge clk) begin
    logic [63:0] expv;
    if (rst) begin
      model_hi = '0;
      model_lo = '0;
    end else begin
      if (done) begin
        if (expq.size() == 0) begin
          checkOutput("done with empty scoreboard", {63'b0, done}, 64'd0);
        end else begin
          expv = expq.pop_front();
          checkOutput("product {hi,lo}", {hi, lo}, expv);
          model_hi = expv[63:32];
          model_lo = expv[31:0];
        end
      end
      if (issue && !stall && funct == F_MFHI) checkOutput("mfhi rd_data", {32'b0, rd_data}, {32'b0, model_hi});
      if (issue && !stall && funct == F_MFLO) checkOutput("mflo rd_data", {32'b0, rd_data}, {32'b0, model_lo});
    end
  end

  // mode: 0 idle, 1 random functs, 2 hold MFHI (also into DONE), 3 hold MULTU with toggling operands then ADD
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input int mode, input bit preissued);
    if (!preissued) begin
      @(posedge clk); #1;
      issue = 1'b1; funct = F_MULTU; a = av; b = bv;
    end
    expq.push_back(refProduct(av, bv));
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      case (mode)
        1: begin issue = 1'b1; funct = pickFunct($urandom_range(0, 3)); a = $urandom; b = $urandom; end
        2: begin issue = 1'b1; funct = F_MFHI; end
        3: begin issue = 1'b1; funct = (i >= 28) ? F_ADD : F_MULTU; a = (i % 2) ? 32'd100 : 32'd55; b = (i % 2) ? 32'd100 : 32'd77; end
        default: begin issue = 1'b0; funct = F_ADD; end
      endcase
      @(negedge clk);
      checkOutput("busy in run", {63'b0, busy}, 64'd1);
      checkOutput("no done in run", {63'b0, done}, 64'd0);
      checkOutput("stall in run", {63'b0, stall}, {63'b0, issue && stallsInRun(funct)});
      if (i < 31) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    if (mode != 2) begin
      issue = 1'b0; funct = F_ADD;
    end
    @(negedge clk);
    checkOutput("done pulse", {63'b0, done}, 64'd1);
    checkOutput("busy clear at done", {63'b0, busy}, 64'd0);
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle no done", {63'b0, done}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] p;
    checks = 0; passes = 0;
    rst = 1'b1; issue = 1'b0; funct = F_ADD; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    // MULTU under reset must be ignored
    issue = 1'b1; funct = F_MULTU; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; issue = 1'b0; funct = F_ADD;
    @(negedge clk);
    checkOutput("reset busy", {63'b0, busy}, 64'd0);
    checkOutput("reset done", {63'b0, done}, 64'd0);
    checkOutput("reset stall", {63'b0, stall}, 64'd0);
    checkOutput("reset hi/lo", {hi, lo}, 64'd0);
    checkOutput("reset rd_data", {32'b0, rd_data}, 64'd0);
    issue = 1'b1; funct = F_MFHI;
    @(negedge clk);
    checkOutput("reset mfhi stall", {63'b0, stall}, 64'd0);
    issue = 1'b0; funct = F_ADD;

    applyStimulus(32'd3, 32'd5, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b0);
    p = refProduct(32'h1234_5678, 32'h9ABC_DEF0);
    checkOutput("mfhi stall in done", {63'b0, stall}, 64'd0);
    checkOutput("mfhi in done", {32'b0, rd_data}, {32'b0, p[63:32]});
    funct = F_MFLO;
    #1;
    checkOutput("mflo after done", {32'b0, rd_data}, {32'b0, p[31:0]});
    issue = 1'b0; funct = F_ADD;

    // Back-to-back: second MULTU presented during the first one's DONE cycle
    applyStimulus(32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    issue = 1'b1; funct = F_MULTU; a = 32'd7; b = 32'd6;
    #1;
    checkOutput("multu in done no stall", {63'b0, stall}, 64'd0);
    applyStimulus(32'd7, 32'd6, 0, 1'b1);

    // Abort mid-run via reset
    @(posedge clk); #1;
    issue = 1'b1; funct = F_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    issue = 1'b0; funct = F_ADD;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", {63'b0, busy}, 64'd0);
    checkOutput("abort hi/lo", {hi, lo}, 64'd0);
    idleCheck(40);
    applyStimulus(32'd2, 32'd2, 0, 1'b0);

    applyStimulus(32'd4, 32'd4, 3, 1'b0);
    idleCheck(40);

    for (int n = 0; n < 8; n++) begin
      applyStimulus($urandom, $urandom, (n % 2) ? 1 : 0, 1'b0);
      issue = 1'b1; funct = (n % 2) ? F_MFLO : F_MFHI;
      @(negedge clk);
      issue = 1'b0; funct = F_ADD;
    end
    idleCheck(40);
    checkOutput("scoreboard drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
